// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
//   Shared types for the CPU front end: 32-bit word, the control unit's PC
//   select encoding, and the fetch-stage state encoding. Also carries the
//   16-bit immediate sign-extension used for branch targets.
// ----------------------------------------------------------------------------
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   // Encoding matches the control unit's PCSel output.
   typedef enum logic [1:0] {
      PC_JUMP   = 2'b00,
      PC_BRANCH = 2'b01,
      PC_JR     = 2'b10,
      PC_NPC    = 2'b11
   } pcsel_t;

   typedef enum logic {
      FETCH_RUN    = 1'b0,
      FETCH_HALTED = 1'b1
   } fetch_state_t;

   localparam word_t INSTR_BYTES = 32'd4;

   function automatic word_t sext_imm16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/fetch_stage_next_pc.sv
// ----------------------------------------------------------------------------
// next_pc_logic
//   Combinational redirect decision and target mux for the fetch stage.
//   Ports:
//     if_valid, stall          : decode-valid qualification (dv = if_valid & ~stall)
//     instr_index [25:0]       : low 26 bits of the IF/ID instruction
//     if_npc [31:0]            : IF/ID PC+4, base for jump/branch targets
//     pc_sel [1:0]             : pcsel_t from the control unit
//     branch, branch_sel, zero : branch qualification (BNE when branch_sel=1)
//     jr_addr [31:0]           : register target for JR
//     take                     : redirect this cycle
//     target [31:0]            : redirect address (meaningful only when take=1)
// ----------------------------------------------------------------------------
module next_pc_logic
   import cpu_types_pkg::*;
(
   input  logic        if_valid,
   input  logic        stall,
   input  logic [25:0] instr_index,
   input  logic [31:0] if_npc,
   input  logic [1:0]  pc_sel,
   input  logic        branch,
   input  logic        branch_sel,
   input  logic        zero,
   input  logic [31:0] jr_addr,
   output logic        take,
   output logic [31:0] target
);

   logic  dv;
   logic  branch_cond;
   word_t jump_target;
   word_t branch_target;

   assign dv          = if_valid & ~stall;
   // BEQ taken on zero, BNE taken on ~zero.
   assign branch_cond = branch & (zero ^ branch_sel);
   assign jump_target = {if_npc[31:28], instr_index, 2'b00};
   // Immediate is sign-extended locally from the raw instruction bits.
   assign branch_target = if_npc + (sext_imm16(instr_index[15:0]) << 2);

   always_comb begin
      take   = 1'b0;
      target = if_npc;
      case (pcsel_t'(pc_sel))
         PC_JUMP: begin
            take   = dv;
            target = jump_target;
         end
         PC_BRANCH: begin
            // With branch=0 this degenerates to NPC.
            take   = dv & branch_cond;
            target = branch_target;
         end
         PC_JR: begin
            take   = dv;
            target = jr_addr;
         end
         default: begin
            take   = 1'b0;
            target = if_npc;
         end
      endcase
   end

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch: owns the PC, drives the icache request and holds the
//   IF/ID latch (instruction + PC+4). Applies decode-resolved redirects
//   (jump, branch, JR), squashes wrong-path fetches and stops on HALT.
//   Optional feature macro: IFETCH_PERF_EN adds saturating fetch/stall
//   counters (fetch_cnt, stall_cnt) and the CNT_W parameter.
//   Ports:
//     CLK, nRST          : clock, asynchronous active-low reset
//     ihit, iload        : icache response
//     iREN, iaddr        : icache request (iaddr = PC)
//     stall              : downstream stall, freezes PC / IF/ID / state
//     PCSel, branch, branchSel, zero, jr_addr, halt : decode redirect inputs
//     if_instr, if_npc, if_valid : IF/ID latch
//     halted             : fetch stopped by HALT (exit only via nRST)
//     fetch_cnt, stall_cnt (IFETCH_PERF_EN only)
// ----------------------------------------------------------------------------
module fetch_stage
   import cpu_types_pkg::*;
#(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
`ifdef IFETCH_PERF_EN
   ,
   parameter int CNT_W = 32
`endif
)(
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic [31:0] iload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        stall,
   input  logic [1:0]  PCSel,
   input  logic        branch,
   input  logic        branchSel,
   input  logic        zero,
   input  logic [31:0] jr_addr,
   input  logic        halt,
   output logic [31:0] if_instr,
   output logic [31:0] if_npc,
   output logic        if_valid,
   output logic        halted
`ifdef IFETCH_PERF_EN
   ,
   output logic [CNT_W-1:0] fetch_cnt,
   output logic [CNT_W-1:0] stall_cnt
`endif
);

   fetch_state_t state_reg, state_next;
   word_t        pc_reg, pc_next;
   word_t        if_instr_reg, if_instr_next;
   word_t        if_npc_reg, if_npc_next;
   logic         if_valid_reg, if_valid_next;
   logic         take;
   word_t        target;
   word_t        pc_plus4;

   assign pc_plus4 = pc_reg + INSTR_BYTES;   // wraps naturally at 2^32

   next_pc_logic u_next_pc (
      .if_valid    (if_valid_reg),
      .stall       (stall),
      .instr_index (if_instr_reg[25:0]),
      .if_npc      (if_npc_reg),
      .pc_sel      (PCSel),
      .branch      (branch),
      .branch_sel  (branchSel),
      .zero        (zero),
      .jr_addr     (jr_addr),
      .take        (take),
      .target      (target)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_reg    <= FETCH_RUN;
         pc_reg       <= PC_INIT;
         if_instr_reg <= '0;
         if_npc_reg   <= '0;
         if_valid_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         if_instr_reg <= if_instr_next;
         if_npc_reg   <= if_npc_next;
         if_valid_reg <= if_valid_next;
      end
   end

   // Priority: stall > halt > redirect > ihit > bubble.
   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      if_instr_next = if_instr_reg;
      if_npc_next   = if_npc_reg;
      if_valid_next = if_valid_reg;
      if (state_reg == FETCH_HALTED) begin
         if_valid_next = 1'b0;
      end else if (stall) begin
         // Hold everything; any returning word is refetched after the stall.
      end else if (if_valid_reg && halt) begin
         state_next    = FETCH_HALTED;
         if_valid_next = 1'b0;
      end else if (take) begin
         // No delay slot: the word fetched alongside the redirect is squashed.
         pc_next       = target;
         if_valid_next = 1'b0;
      end else if (ihit) begin
         pc_next       = pc_plus4;
         if_instr_next = iload;
         if_npc_next   = pc_plus4;
         if_valid_next = 1'b1;
      end else begin
         if_valid_next = 1'b0;
      end
   end

   assign iREN     = (state_reg == FETCH_RUN);
   assign iaddr    = pc_reg;
   assign if_instr = if_instr_reg;
   assign if_npc   = if_npc_reg;
   assign if_valid = if_valid_reg;
   assign halted   = (state_reg == FETCH_HALTED);

`ifdef IFETCH_PERF_EN
   logic             latch_hit;
   logic             count_stall;
   logic [CNT_W-1:0] fetch_cnt_reg;
   logic [CNT_W-1:0] stall_cnt_reg;

   assign latch_hit   = (state_reg == FETCH_RUN) & ~stall & ~(if_valid_reg & halt)
                        & ~take & ihit;
   assign count_stall = (state_reg == FETCH_RUN) & (~ihit | stall);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         fetch_cnt_reg <= '0;
         stall_cnt_reg <= '0;
      end else begin
         if (latch_hit && !(&fetch_cnt_reg))
            fetch_cnt_reg <= fetch_cnt_reg + CNT_W'(1);
         if (count_stall && !(&stall_cnt_reg))
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
   end

   assign fetch_cnt = fetch_cnt_reg;
   assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. The bench plays both icache and
//   control unit. Each latched fetch pushes {instr, PC+4} onto a scoreboard
//   queue; entries are popped when the IF/ID latch presents a new valid word.
//   Define IFETCH_PERF_EN to also exercise the perf counters (CNT_W=4).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_stage;
   import cpu_types_pkg::*;

   localparam logic [31:0] PC_INIT = 32'h0000_0000;
`ifdef IFETCH_PERF_EN
   localparam int CNT_W = 4;
`endif

   localparam logic [31:0] W_BEQ  = 32'h1022_FFFE;  // beq imm=-2
   localparam logic [31:0] W_BNE  = 32'h1422_0003;  // bne imm=3
   localparam logic [31:0] W_JR   = 32'h0220_0008;
   localparam logic [31:0] W_J    = 32'h0800_0040;  // j index=0x40
   localparam logic [31:0] W_HALT = 32'hFFFF_FFFF;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        ihit = 1'b0;
   logic [31:0] iload = '0;
   logic        stall = 1'b0;
   logic [1:0]  PCSel = 2'b11;
   logic        branch = 1'b0;
   logic        branchSel = 1'b0;
   logic        zero = 1'b0;
   logic [31:0] jr_addr = '0;
   logic        halt = 1'b0;
   logic        iREN;
   logic [31:0] iaddr;
   logic [31:0] if_instr;
   logic [31:0] if_npc;
   logic        if_valid;
   logic        halted;
`ifdef IFETCH_PERF_EN
   logic [CNT_W-1:0] fetch_cnt;
   logic [CNT_W-1:0] stall_cnt;
`endif

   fetch_stage #(
      .PC_INIT (PC_INIT)
`ifdef IFETCH_PERF_EN
      ,
      .CNT_W   (CNT_W)
`endif
   ) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .ihit      (ihit),
      .iload     (iload),
      .iREN      (iREN),
      .iaddr     (iaddr),
      .stall     (stall),
      .PCSel     (PCSel),
      .branch    (branch),
      .branchSel (branchSel),
      .zero      (zero),
      .jr_addr   (jr_addr),
      .halt      (halt),
      .if_instr  (if_instr),
      .if_npc    (if_npc),
      .if_valid  (if_valid),
      .halted    (halted)
`ifdef IFETCH_PERF_EN
      ,
      .fetch_cnt (fetch_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] npc;
   } sb_entry_t;

   sb_entry_t   sb_q[$];
   int          n_checks = 0;
   int          n_bad = 0;
   int          n_txn = 0;
   logic [31:0] exp_pc = PC_INIT;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic set_ctl(input logic [1:0] sel, input logic br, input logic bsel,
                          input logic z, input logic [31:0] jr, input logic hlt,
                          input logic stl);
      PCSel     = sel;
      branch    = br;
      branchSel = bsel;
      zero      = z;
      jr_addr   = jr;
      halt      = hlt;
      stall     = stl;
   endtask

   task automatic idle_ctl();
      set_ctl(2'b11, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   // One clock. exp_latch: this cycle's ihit word must enter IF/ID.
   task automatic tick(input bit exp_latch, input bit exp_valid, input logic [31:0] exp_next_pc);
      sb_entry_t e;
      if (exp_latch) begin
         e.instr = iload;
         e.npc   = exp_pc + 32'd4;
         sb_q.push_back(e);
      end
      @(posedge CLK);
      #1;
      n_txn++;
      exp_pc = exp_next_pc;
      $display("txn %0d: iaddr=%h iREN=%b if_valid=%b if_instr=%h if_npc=%h halted=%b",
               n_txn, iaddr, iREN, if_valid, if_instr, if_npc, halted);
      check_eq("iaddr", iaddr, exp_pc);
      check_eq("if_valid", 32'(if_valid), 32'(exp_valid));
      if (if_valid && !stall) begin
         check_eq("sb_pending", 32'(sb_q.size()), 32'd1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("if_instr", if_instr, e.instr);
            check_eq("if_npc", if_npc, e.npc);
         end
      end
   endtask

   task automatic reset_pulse();
      #2;
      nRST = 1'b0;
      #1;
      check_eq("rst_iaddr", iaddr, PC_INIT);
      check_eq("rst_iREN", 32'(iREN), 32'd1);
      check_eq("rst_halted", 32'(halted), 32'd0);
      check_eq("rst_if_valid", 32'(if_valid), 32'd0);
      exp_pc = PC_INIT;
      idle_ctl();
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   initial begin
      // Reset state
      #12;
      check_eq("reset_iaddr", iaddr, PC_INIT);
      check_eq("reset_iREN", 32'(iREN), 32'd1);
      check_eq("reset_if_instr", if_instr, 32'h0);
      check_eq("reset_if_npc", if_npc, 32'h0);
      check_eq("reset_if_valid", 32'(if_valid), 32'd0);
      check_eq("reset_halted", 32'(halted), 32'd0);
`ifdef IFETCH_PERF_EN
      check_eq("reset_fetch_cnt", 32'(fetch_cnt), 32'd0);
      check_eq("reset_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      @(negedge CLK);
      nRST = 1'b1;
      ihit = 1'b1;
      idle_ctl();

      // Straight-line fetch 0,4,8,C; BEQ sits at 0xC so its npc is 0x10
      for (int i = 0; i < 3; i++) begin
         iload = $urandom;
         tick(1'b1, 1'b1, exp_pc + 32'd4);
      end
      iload = W_BEQ;
      tick(1'b1, 1'b1, 32'h10);

      // BEQ taken: 0x10 + (-2 << 2) = 0x08, fetched word squashed
      set_ctl(2'b01, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      iload = $urandom;
      tick(1'b0, 1'b0, 32'h08);

      // Refill to put BEQ back in IF/ID with npc=0x10, then not taken
      idle_ctl();
      iload = $urandom;
      tick(1'b1, 1'b1, 32'h0C);
      iload = W_BEQ;
      tick(1'b1, 1'b1, 32'h10);
      set_ctl(2'b01, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      iload = $urandom;
      tick(1'b1, 1'b1, 32'h14);

      // BNE with zero=0, npc=0x20, imm=3 -> 0x2C
      idle_ctl();
      iload = $urandom;
      tick(1'b1, 1'b1, 32'h18);
      iload = $urandom;
      tick(1'b1, 1'b1, 32'h1C);
      iload = W_BNE;
      tick(1'b1, 1'b1, 32'h20);
      set_ctl(2'b01, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      iload = $urandom;
      tick(1'b0, 1'b0, 32'h2C);

      // JR into 0x1000_0000, then J with npc=0x1000_0004 -> 0x1000_0100
      idle_ctl();
      iload = W_JR;
      tick(1'b1, 1'b1, 32'h30);
      set_ctl(2'b10, 1'b0, 1'b0, 1'b0, 32'h1000_0000, 1'b0, 1'b0);
      iload = $urandom;
      tick(1'b0, 1'b0, 32'h1000_0000);
      idle_ctl();
      iload = W_J;
      tick(1'b1, 1'b1, 32'h1000_0004);
      set_ctl(2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      iload = $urandom;
      tick(1'b0, 1'b0, 32'h1000_0100);

      // JR held off by a 3-cycle stall, then redirect to 0x200
      idle_ctl();
      iload = W_JR;
      tick(1'b1, 1'b1, 32'h1000_0104);
      set_ctl(2'b10, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         iload = $urandom;
         tick(1'b0, 1'b1, 32'h1000_0104);
         check_eq("stall_hold_instr", if_instr, W_JR);
      end
      stall = 1'b0;
      tick(1'b0, 1'b0, 32'h200);

      // PCSel=BRANCH with branch=0 behaves as NPC
      idle_ctl();
      iload = $urandom;
      tick(1'b1, 1'b1, 32'h204);
      set_ctl(2'b01, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      iload = $urandom;
      tick(1'b1, 1'b1, 32'h208);

      // icache miss: bubble, PC holds
      idle_ctl();
      ihit = 1'b0;
      tick(1'b0, 1'b0, 32'h208);

      // HALT in decode wins over a concurrent jump; fetch then freezes
      ihit = 1'b1;
      iload = W_HALT;
      tick(1'b1, 1'b1, 32'h20C);
      set_ctl(2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      iload = $urandom;
      tick(1'b0, 1'b0, 32'h20C);
      check_eq("halt_halted", 32'(halted), 32'd1);
      check_eq("halt_iREN", 32'(iREN), 32'd0);
      idle_ctl();
      iload = $urandom;
      tick(1'b0, 1'b0, 32'h20C);
      check_eq("halt_sticky", 32'(halted), 32'd1);

      // Asynchronous reset mid-cycle leaves HALTED immediately
      reset_pulse();

      // PC+4 wrap from 0xFFFF_FFFC to 0
      iload = $urandom;
      tick(1'b1, 1'b1, 32'h4);
      set_ctl(2'b10, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0);
      iload = $urandom;
      tick(1'b0, 1'b0, 32'hFFFF_FFFC);
      idle_ctl();
      iload = $urandom;
      tick(1'b1, 1'b1, 32'h0);

`ifdef IFETCH_PERF_EN
      reset_pulse();
      ihit = 1'b1;
      for (int i = 0; i < 5; i++) begin
         iload = $urandom;
         tick(1'b1, 1'b1, exp_pc + 32'd4);
      end
      ihit = 1'b0;
      for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, exp_pc);
      check_eq("fetch_cnt", 32'(fetch_cnt), 32'd5);
      check_eq("stall_cnt", 32'(stall_cnt), 32'd2);
      ihit = 1'b1;
      for (int i = 0; i < 15; i++) begin
         iload = $urandom;
         tick(1'b1, 1'b1, exp_pc + 32'd4);
      end
      check_eq("fetch_cnt_sat", 32'(fetch_cnt), 32'd15);
      check_eq("stall_cnt_hold", 32'(stall_cnt), 32'd2);
`endif

      check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
